morse_key_decoder: RTL and testbench

Receive-side counterpart of the PS/2-to-Morse path. It takes a single hand-keyed Morse input, such as a straight key on an input switch. It times marks and spaces in units of a parameterised dit length and classifies each element as dit or dah. It assembles the elements into a character and emits the ASCII code as a one-cycle strobe, so that a downstream display or PS/2-side block can consume it.

---
 rtl/morse_pkg.sv | 21 ++
 rtl/morse_lut.sv | 54 +++++
 rtl/morse_key_decoder.sv | 166 ++++++++++++++++
 tb/tb_morse_key_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key decoder and its lookup table.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  localparam int PATTERN_W = 6;
  localparam int COUNT_W   = 3;
  localparam int UNITS_W   = 3;

  localparam logic [UNITS_W-1:0] DIT_DAH_THRESH = 3'd2;
  localparam logic [UNITS_W-1:0] WORD_GAP       = 3'd5;
  localparam logic [UNITS_W-1:0] UNITS_MAX      = 3'd7;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational {element count, element pattern} -> ASCII table.
// Pattern holds the first element in the MSB of the used bits; 1 = dah.
module morse_lut
  import morse_pkg::*;
(
  input  logic [COUNT_W-1:0]   count,
  input  logic [PATTERN_W-1:0] pattern,
  output logic [7:0]           ascii
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    case ({count, pattern})
      {3'd1, 6'b000000}: ascii = 8'h45;
      {3'd1, 6'b000001}: ascii = 8'h54;
      {3'd2, 6'b000000}: ascii = 8'h49;
      {3'd2, 6'b000001}: ascii = 8'h41;
      {3'd2, 6'b000010}: ascii = 8'h4E;
      {3'd2, 6'b000011}: ascii = 8'h4D;
      {3'd3, 6'b000000}: ascii = 8'h53;
      {3'd3, 6'b000001}: ascii = 8'h55;
      {3'd3, 6'b000010}: ascii = 8'h52;
      {3'd3, 6'b000011}: ascii = 8'h57;
      {3'd3, 6'b000100}: ascii = 8'h44;
      {3'd3, 6'b000101}: ascii = 8'h4B;
      {3'd3, 6'b000110}: ascii = 8'h47;
      {3'd3, 6'b000111}: ascii = 8'h4F;
      {3'd4, 6'b000000}: ascii = 8'h48;
      {3'd4, 6'b000001}: ascii = 8'h56;
      {3'd4, 6'b000010}: ascii = 8'h46;
      {3'd4, 6'b000100}: ascii = 8'h4C;
      {3'd4, 6'b000110}: ascii = 8'h50;
      {3'd4, 6'b000111}: ascii = 8'h4A;
      {3'd4, 6'b001000}: ascii = 8'h42;
      {3'd4, 6'b001001}: ascii = 8'h58;
      {3'd4, 6'b001010}: ascii = 8'h43;
      {3'd4, 6'b001011}: ascii = 8'h59;
      {3'd4, 6'b001100}: ascii = 8'h5A;
      {3'd4, 6'b001101}: ascii = 8'h51;
      {3'd5, 6'b000000}: ascii = 8'h35;
      {3'd5, 6'b000001}: ascii = 8'h34;
      {3'd5, 6'b000011}: ascii = 8'h33;
      {3'd5, 6'b000111}: ascii = 8'h32;
      {3'd5, 6'b001111}: ascii = 8'h31;
      {3'd5, 6'b010000}: ascii = 8'h36;
      {3'd5, 6'b011000}: ascii = 8'h37;
      {3'd5, 6'b011100}: ascii = 8'h38;
      {3'd5, 6'b011110}: ascii = 8'h39;
      {3'd5, 6'b011111}: ascii = 8'h30;
      default:           ascii = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse receiver: synchronises and debounces the key, times marks
// and spaces in dit units, and emits each decoded character as an ASCII strobe.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 600000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_ELEMENTS    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       dit_pulse,
  output logic       dah_pulse,
  output logic       busy
);

  localparam int PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic                 key_s1, key_s2, key_f, key_f_d;
  logic [DB_W-1:0]      db_cnt;
  logic [PRE_W-1:0]     prescaler;
  logic [UNITS_W-1:0]   units;
  logic                 key_rise, key_fall, mark_is_dah;
  state_t               state, state_next;
  logic [PATTERN_W-1:0] pattern, pattern_next;
  logic [COUNT_W-1:0]   count, count_next;
  logic                 overflow, overflow_next;
  logic                 char_done, char_done_next;
  logic                 char_valid_next, dit_next, dah_next;
  logic [7:0]           char_data_next, lut_ascii;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
      key_f   <= 1'b0;
      key_f_d <= 1'b0;
      db_cnt  <= '0;
    end else begin
      key_s1  <= key_in;
      key_s2  <= key_s1;
      key_f_d <= key_f;
      if (key_s2 == key_f) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_f  <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign key_rise    = key_f & ~key_f_d;
  assign key_fall    = ~key_f & key_f_d;
  assign mark_is_dah = (units >= DIT_DAH_THRESH);
  assign busy        = (state != IDLE);

  // Every filtered key edge restarts the unit timing for the next mark/space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      units     <= '0;
    end else if (key_rise || key_fall) begin
      prescaler <= '0;
      units     <= '0;
    end else if (prescaler == PRE_W'(UNIT_CYCLES - 1)) begin
      prescaler <= '0;
      if (units != UNITS_MAX) units <= units + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  morse_lut u_lut (
    .count   (count),
    .pattern (pattern),
    .ascii   (lut_ascii)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pattern    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      char_done  <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
      dit_pulse  <= 1'b0;
      dah_pulse  <= 1'b0;
    end else begin
      state      <= state_next;
      pattern    <= pattern_next;
      count      <= count_next;
      overflow   <= overflow_next;
      char_done  <= char_done_next;
      char_valid <= char_valid_next;
      char_data  <= char_data_next;
      dit_pulse  <= dit_next;
      dah_pulse  <= dah_next;
    end
  end

  always_comb begin
    state_next      = state;
    pattern_next    = pattern;
    count_next      = count;
    overflow_next   = overflow;
    char_done_next  = char_done;
    char_valid_next = 1'b0;
    char_data_next  = char_data;
    dit_next        = 1'b0;
    dah_next        = 1'b0;
    case (state)
      IDLE: begin
        if (key_rise) begin
          state_next     = MARK;
          char_done_next = 1'b0;
        end
      end
      MARK: begin
        if (key_fall) begin
          dah_next   = mark_is_dah;
          dit_next   = ~mark_is_dah;
          state_next = SPACE;
          if (count == COUNT_W'(MAX_ELEMENTS)) begin
            overflow_next = 1'b1;
          end else begin
            pattern_next = {pattern[PATTERN_W-2:0], mark_is_dah};
            count_next   = count + 1'b1;
          end
        end
      end
      SPACE: begin
        // A mark starting on the very cycle the character ends still sees
        // the character emitted first and begins with an empty symbol.
        if (!char_done && units == DIT_DAH_THRESH) begin
          char_valid_next = 1'b1;
          char_data_next  = overflow ? ASCII_UNKNOWN : lut_ascii;
          pattern_next    = '0;
          count_next      = '0;
          overflow_next   = 1'b0;
          char_done_next  = 1'b1;
          if (key_rise) begin
            state_next     = MARK;
            char_done_next = 1'b0;
          end
        end else if (key_rise) begin
          state_next     = MARK;
          char_done_next = 1'b0;
        end else if (char_done && units == WORD_GAP) begin
          char_valid_next = 1'b1;
          char_data_next  = ASCII_SPACE;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Randomised and directed bench for morse_key_decoder, checked against a
// duration-based Morse model working on dot/dash strings.
module tb_morse_key_decoder;

  localparam int U      = 10;
  localparam int D      = 4;
  localparam int MAXE   = 6;
  localparam int DIT_EV = 256;
  localparam int DAH_EV = 257;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic [7:0] char_data;
  logic       char_valid, dit_pulse, dah_pulse, busy;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;
  int last_fall_cyc = 0;
  int seq[$];
  int exp_ev[$];
  int obs_ev[$];
  int obs_cyc[$];

  string morse_tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."
  };

  morse_key_decoder #(
    .UNIT_CYCLES     (U),
    .DEBOUNCE_CYCLES (D),
    .MAX_ELEMENTS    (MAXE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .char_data  (char_data),
    .char_valid (char_valid),
    .dit_pulse  (dit_pulse),
    .dah_pulse  (dah_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (dit_pulse) begin obs_ev.push_back(DIT_EV); obs_cyc.push_back(cycle); end
    if (dah_pulse) begin obs_ev.push_back(DAH_EV); obs_cyc.push_back(cycle); end
    if (char_valid) begin obs_ev.push_back(int'(char_data)); obs_cyc.push_back(cycle); end
  end

  function automatic logic [7:0] decode(string s, bit ovf);
    if (ovf) return 8'h3F;
    for (int k = 0; k < 36; k++)
      if (s == morse_tbl[k]) return (k < 26) ? 8'(8'h41 + k) : 8'(8'h30 + k - 26);
    return 8'h3F;
  endfunction

  // Alternating mark/space durations in seq; marks longer than two units are
  // dashes, spaces longer than two units end a character, and spaces that
  // outlast five units also produce a word space.
  function automatic void model_seq();
    string cur;
    string e;
    bit    ovf;
    bit    is_dah;
    cur = "";
    ovf = 1'b0;
    for (int i = 0; i < seq.size(); i += 2) begin
      is_dah = (seq[i] > 2 * U);
      exp_ev.push_back(is_dah ? DAH_EV : DIT_EV);
      e = is_dah ? "-" : ".";
      if (cur.len() == MAXE) ovf = 1'b1;
      else cur = {cur, e};
      if (i + 1 < seq.size() && seq[i+1] > 2 * U) begin
        exp_ev.push_back(int'(decode(cur, ovf)));
        cur = "";
        ovf = 1'b0;
        if (seq[i+1] >= 5 * U + 2) exp_ev.push_back(32);
      end
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic play_seq();
    for (int i = 0; i < seq.size(); i++) begin
      key_in = (i % 2 == 0);
      if (i % 2 == 1) last_fall_cyc = cycle;
      wait_cycles(seq[i]);
    end
    key_in = 1'b0;
  endtask

  task automatic start_case();
    obs_ev.delete();
    obs_cyc.delete();
    exp_ev.delete();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 1'b0;
    @(posedge clk); #1;
    wait_cycles(3);
    if (char_valid !== 1'b0) $display("[TB] FAIL reset_char_valid: got %0b expected 0", char_valid); else passed++;
    checks++;
    if (dit_pulse !== 1'b0) $display("[TB] FAIL reset_dit: got %0b expected 0", dit_pulse); else passed++;
    checks++;
    if (dah_pulse !== 1'b0) $display("[TB] FAIL reset_dah: got %0b expected 0", dah_pulse); else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passed++;
    checks++;
    if (char_data !== 8'h00) $display("[TB] FAIL reset_char_data: got %0h expected 0", char_data); else passed++;
    checks++;
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single_dit();
    int lat;
    start_case();
    seq = '{10, 100};
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL dit_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL dit_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
    lat = (obs_cyc.size() > 1) ? obs_cyc[1] - last_fall_cyc : -1;
    if (lat < 2 + D + 2 * U || lat > 2 + D + 2 * U + 3)
      $display("[TB] FAIL dit_latency: got %0d cycles expected %0d..%0d", lat, 2 + D + 2 * U, 2 + D + 2 * U + 3);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL dit_busy_after: got %0b expected 0", busy); else passed++;
    checks++;
  endtask

  task automatic test_dit_dah();
    start_case();
    seq = '{10, 10, 30, 100};
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL a_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL a_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_five_dahs();
    start_case();
    seq.delete();
    for (int i = 0; i < 5; i++) begin seq.push_back(30); seq.push_back(10); end
    seq[9] = 100;
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL zero_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL zero_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_overflow();
    start_case();
    seq.delete();
    for (int i = 0; i < 7; i++) begin seq.push_back(10); seq.push_back(10); end
    seq[13] = 100;
    seq.push_back(10);
    seq.push_back(100);
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL ovf_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL ovf_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_long_mark();
    start_case();
    seq = '{200, 100};
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL sat_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL sat_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    start_case();
    seq = '{10, 10, 30, 30, 30, 100};
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL b2b_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL b2b_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_reset_mid_mark();
    key_in = 1'b1;
    wait_cycles(15);
    if (busy !== 1'b1) $display("[TB] FAIL midmark_busy: got %0b expected 1", busy); else passed++;
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({char_valid, dit_pulse, dah_pulse, busy} !== 4'b0000)
      $display("[TB] FAIL async_reset_outputs: got %b expected 0000", {char_valid, dit_pulse, dah_pulse, busy});
    else passed++;
    checks++;
    @(posedge clk); #1;
    wait_cycles(2);
    key_in = 1'b0;
    rst_n  = 1'b1;
    start_case();
    wait_cycles(100);
    if (obs_ev.size() != 0) $display("[TB] FAIL post_reset_quiet: got %0d events expected 0", obs_ev.size()); else passed++;
    checks++;
    start_case();
    seq = '{10, 100};
    model_seq();
    play_seq();
    if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL rst_e_count: got %0d events expected %0d", obs_ev.size(), exp_ev.size()); else passed++;
    checks++;
    for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
      if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL rst_e_ev%0d: got %0d expected %0d", k, obs_ev[k], exp_ev[k]); else passed++;
      checks++;
    end
  endtask

  task automatic test_random();
    int nchars, nel;
    for (int it = 0; it < 6; it++) begin
      start_case();
      seq.delete();
      nchars = $urandom_range(1, 3);
      for (int c = 0; c < nchars; c++) begin
        nel = $urandom_range(1, 7);
        for (int e = 0; e < nel; e++) begin
          seq.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(25, 60) : $urandom_range(6, 15));
          if (e < nel - 1) seq.push_back($urandom_range(6, 15));
          else seq.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(70, 90) : $urandom_range(25, 40));
        end
      end
      seq[seq.size() - 1] = 100;
      model_seq();
      play_seq();
      if (obs_ev.size() != exp_ev.size()) $display("[TB] FAIL rnd%0d_count: got %0d events expected %0d", it, obs_ev.size(), exp_ev.size()); else passed++;
      checks++;
      for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
        if (obs_ev[k] !== exp_ev[k]) $display("[TB] FAIL rnd%0d_ev%0d: got %0d expected %0d", it, k, obs_ev[k], exp_ev[k]); else passed++;
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_dit();
    test_dit_dah();
    test_five_dahs();
    test_overflow();
    test_long_mark();
    test_back_to_back();
    test_reset_mid_mark();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
